delay_ring_reader: RTL and testbench

// - Per-microphone variable delay on a circular RAM with valid/ready on both sides.

---
 rtl/supermic_pkg.sv | 33 +++
 rtl/delay_ram.sv | 36 +++
 rtl/delay_ring_reader.sv | 146 ++++++++++++++
 tb/tb_delay_ring_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/supermic_pkg.sv
// Shared definitions for the beamformer microphone channel blocks.
// Contents:
//   PCM_W / DEPTH / DLY_W : sample width, ring depth, delay/pointer width
//   state_t               : delay_ring_reader FSM states
//   dly_t                 : delay / pointer type
//   slew_step()           : one-step move of a delay toward a target
package supermic_pkg;

    localparam int PCM_W = 19;
    localparam int DEPTH = 64;
    localparam int DLY_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    typedef logic [DLY_W-1:0] dly_t;

    // Move cur one count toward tgt; hold when equal.
    function automatic dly_t slew_step(input dly_t cur, input dly_t tgt);
        dly_t res;
        res = cur;
        if (tgt > cur) begin
            res = cur + dly_t'(1);
        end else if (tgt < cur) begin
            res = cur - dly_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Read data appears one cycle after raddr/re. No reset on the array or
// the read register so synthesis maps it to block RAM.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable
//   raddr  : read address
//   rdata  : registered read data (old contents on a same-address write)
module delay_ram #(
    parameter int W  = 19,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/delay_ring_reader.sv
// Per-microphone variable delay line on a circular RAM.
// Each accepted input sample is written at wp; the sample accepted
// cur_delay samples earlier is read back and presented on the output.
//
// Handshake: a transfer happens on a rising clk edge where valid and
// ready are both high; the source holds data and valid stable until then.
//
// Configuration macro: DELAY_SLEW_EN
//   defined   : at each accept cur_delay steps by one toward the loaded target
//   undefined : at each accept cur_delay jumps straight to the loaded target
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : input sample valid
//   in_ready    : block can accept a sample (high only in S_IDLE)
//   in_pcm      : input sample
//   delay       : requested delay in samples
//   delay_load  : latch delay as new target (honoured only in S_IDLE)
//   out_valid   : delayed sample valid
//   out_ready   : downstream accepts sample
//   out_pcm     : delayed sample
//   cur_delay   : delay currently applied
//   dbg_state   : FSM state for observation
module delay_ring_reader
    import supermic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PCM_W-1:0] in_pcm,
    input  logic [DLY_W-1:0] delay,
    input  logic             delay_load,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PCM_W-1:0] out_pcm,
    output logic [DLY_W-1:0] cur_delay,
    output logic [1:0]       dbg_state
);

    state_t           state;
    state_t           state_next;
    dly_t             wp;
    dly_t             fill;
    dly_t             tgt_delay;
    dly_t             eff_delay;
    dly_t             raddr;
    logic [PCM_W-1:0] bypass;
    logic [PCM_W-1:0] rdata;
    logic             sel_bypass;
    logic             sel_zero;
    logic             accept;
    logic             out_fire;

    assign in_ready  = (state == S_IDLE);
    assign accept    = in_ready && in_valid;
    assign out_fire  = (state == S_OUT) && out_valid && out_ready;
    assign dbg_state = state;

    // Delay used by the sample being accepted; it also becomes cur_delay.
`ifdef DELAY_SLEW_EN
    assign eff_delay = slew_step(cur_delay, tgt_delay);
`else
    assign eff_delay = tgt_delay;
`endif

    // Natural DLY_W wrap gives the mod-DEPTH ring address.
    assign raddr = wp - eff_delay;

    delay_ram #(
        .W  (PCM_W),
        .AW (DLY_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wp),
        .wdata (in_pcm),
        .re    (accept),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = S_READ;
            S_READ:  state_next = S_OUT;
            S_OUT:   if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            fill       <= '0;
            cur_delay  <= '0;
            tgt_delay  <= '0;
            bypass     <= '0;
            sel_bypass <= 1'b0;
            sel_zero   <= 1'b0;
            out_valid  <= 1'b0;
            out_pcm    <= '0;
        end else begin
            // Target is read combinationally by eff_delay before this
            // update lands, so a same-cycle load affects the next sample.
            if (in_ready && delay_load) begin
                tgt_delay <= delay;
            end
            if (accept) begin
                cur_delay  <= eff_delay;
                bypass     <= in_pcm;
                // Decide the source now, while fill still counts only
                // samples written before this one.
                sel_bypass <= (eff_delay == '0);
                sel_zero   <= (eff_delay > fill);
            end
            if (state == S_READ) begin
                out_valid <= 1'b1;
                if (sel_bypass) begin
                    out_pcm <= bypass;
                end else if (sel_zero) begin
                    out_pcm <= '0;
                end else begin
                    out_pcm <= rdata;
                end
            end
            if (out_fire) begin
                out_valid <= 1'b0;
                wp        <= wp + dly_t'(1);
                if (fill != dly_t'(DEPTH - 1)) begin
                    fill <= fill + dly_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_ring_reader.sv
module tb_delay_ring_reader;
    import supermic_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PCM_W-1:0] in_pcm = '0;
    logic [DLY_W-1:0] delay = '0;
    logic             delay_load = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PCM_W-1:0] out_pcm;
    logic [DLY_W-1:0] cur_delay;
    logic [1:0]       dbg_state;

    delay_ring_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pcm     (in_pcm),
        .delay      (delay),
        .delay_load (delay_load),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pcm    (out_pcm),
        .cur_delay  (cur_delay),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [PCM_W-1:0] exp_q[$];
    logic [DLY_W-1:0] exp_dly_q[$];
    int               exp_cyc_q[$];

    // Reference model: every sample accepted since reset, plus delays.
    logic [PCM_W-1:0] hist[$];
    int m_cur = 0;
    int m_tgt = 0;

    bit rand_ready  = 1'b0;
    bit ready_force = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Sample n (0-based since reset) leaves as sample n-d; zero until the
    // ring holds d older samples; d==0 passes the current sample through.
    task automatic model_accept(input logic [PCM_W-1:0] pcm);
        int eff;
        int n;
        int filled;
`ifdef DELAY_SLEW_EN
        if (m_tgt > m_cur) eff = m_cur + 1;
        else if (m_tgt < m_cur) eff = m_cur - 1;
        else eff = m_cur;
`else
        eff = m_tgt;
`endif
        m_cur  = eff;
        n      = hist.size();
        filled = (n > DEPTH - 1) ? DEPTH - 1 : n;
        if (eff == 0) exp_q.push_back(pcm);
        else if (eff > filled) exp_q.push_back('0);
        else exp_q.push_back(hist[n - eff]);
        exp_dly_q.push_back(DLY_W'(eff));
        exp_cyc_q.push_back(cyc + 2);
        hist.push_back(pcm);
    endtask

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send(input logic [PCM_W-1:0] pcm, input bit load, input int dly);
        int  waited = 0;
        bit  done   = 1'b0;
        in_valid   = 1'b1;
        in_pcm     = pcm;
        delay_load = load;
        delay      = DLY_W'(dly);
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(pcm);
                if (load) m_tgt = dly;
                done = 1'b1;
            end else if (++waited > 50) begin
                timeout_fail("send_accept");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b0;
        delay_load = 1'b0;
    endtask

    task automatic load_delay(input int dly);
        int waited = 0;
        bit done   = 1'b0;
        delay_load = 1'b1;
        delay      = DLY_W'(dly);
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                m_tgt = dly;
                done  = 1'b1;
            end else if (++waited > 50) begin
                timeout_fail("load_delay");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        delay_load = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (exp_q.size() != 0) timeout_fail("drain");
    endtask

    task automatic wait_out_valid();
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) timeout_fail("wait_out_valid");
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_dly_q.delete();
        exp_cyc_q.delete();
        hist.delete();
        m_cur = 0;
        m_tgt = 0;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        delay_load = 1'b0;
        rst_n      = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // ---------------- monitor ----------------
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid && exp_cyc_q.size() != 0)
                check("latency", cyc, exp_cyc_q[0]);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_output");
                end else begin
                    check("out_pcm", out_pcm, exp_q.pop_front());
                    check("cur_delay", cur_delay, exp_dly_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [PCM_W-1:0] v;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pcm", out_pcm, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cur_delay", cur_delay, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Delay 0: pass-through of 1,2,3
        ready_force = 1'b1;
        for (int i = 1; i <= 3; i++) send(PCM_W'(i), 1'b0, 0);
        drain();

        // Delay step 0 -> 5 over 8 samples
        load_delay(5);
        for (int i = 0; i < 8; i++) send(PCM_W'(100 + i), 1'b0, 0);
        drain();

        // Delay 4 on a fresh ring: 10..100
        do_reset();
        load_delay(4);
        for (int i = 1; i <= 10; i++) send(PCM_W'(10 * i), 1'b0, 0);
        drain();

        // Delay 63 across pointer wrap
        do_reset();
        load_delay(63);
        for (int i = 0; i < 200; i++) send(PCM_W'(1000 + i), 1'b0, 0);
        drain();

        // Stall in S_OUT; input and delay_load offered meanwhile are ignored
        ready_force = 1'b0;
        send(PCM_W'(12345), 1'b0, 0);
        wait_out_valid();
        in_valid   = 1'b1;
        in_pcm     = PCM_W'(77);
        delay_load = 1'b1;
        delay      = DLY_W'(33);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            if (exp_q.size() != 0) check("stall_pcm", out_pcm, exp_q[0]);
        end
        in_valid    = 1'b0;
        delay_load  = 1'b0;
        ready_force = 1'b1;
        drain();
        // Target must still be 63: next sample reads 63 back
        send(PCM_W'(4242), 1'b0, 0);
        drain();

        // Reset while output pending
        ready_force = 1'b0;
        send(PCM_W'(555), 1'b0, 0);
        wait_out_valid();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        load_delay(2);
        for (int i = 0; i < 4; i++) send(PCM_W'(300 + i), 1'b0, 0);
        drain();

        // Randomized: random data, delays, gaps, same-cycle loads, backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            v = PCM_W'($urandom());
            if ($urandom_range(0, 7) == 0) load_delay($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 9) == 0) send(v, 1'b1, $urandom_range(0, DEPTH - 1));
            else send(v, 1'b0, 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
